mem_port_arbiter: RTL and testbench

Shares the single data-memory port (mreq/write/addr/wr_data/rd_data) between instruction fetch and the memory stage of the RV32I pipeline. Serialises one access at a time through an IDLE/BUSY/RESP state machine and tolerates a variable-latency memory via mem_ready. Data accesses have priority; a fetch starvation counter guarantees forward progress. Sits between the IF/MEM stages and the memory model.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, grant encoding and
// the width of the fetch starvation counter.
package mem_arb_pkg;

    // Wide enough for the largest legal MAX_WAIT (15).
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave = the arbiter itself; master = the pipeline stages plus memory model.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_mreq;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_ready;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_rd_data, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata, mem_mreq, mem_write, mem_addr, mem_wr_data,
               bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_rd_data, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_mreq, mem_write, mem_addr, mem_wr_data,
               bus_err
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational grant selection: data wins unless a waiting fetch has already
// lost MAX_WAIT consecutive arbitrations.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              if_req,
    input  logic              d_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic              grant_valid,
    output grant_e            grant
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = if_req | d_req;
        grant       = GNT_FETCH;
        if (d_req && (!if_req || wait_cnt < MAX_WAIT_C)) begin
            grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto the single memory port (IDLE/BUSY/RESP).
// Optional macro ARB_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles with bus_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 16
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    state_e            state;
    grant_e            gnt_q;
    logic              write_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic   pick_valid;
    grant_e pick_gnt;

    logic        resp_done;
    logic        resp_err;
    logic [31:0] resp_data;

    arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .wait_cnt    (wait_cnt),
        .grant_valid (pick_valid),
        .grant       (pick_gnt)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] busy_cnt;
`endif

    // Completion of the current BUSY access: memory handshake, or an abort.
    always_comb begin
        resp_done = bus.mem_ready;
        resp_err  = 1'b0;
        resp_data = bus.mem_rd_data;
`ifdef ARB_TIMEOUT_EN
        if (!bus.mem_ready && busy_cnt == TO_LAST) begin
            resp_done = 1'b1;
            resp_err  = 1'b1;
            resp_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            gnt_q           <= GNT_FETCH;
            write_q         <= 1'b0;
            wait_cnt        <= '0;
            bus.if_ack      <= 1'b0;
            bus.if_rdata    <= '0;
            bus.d_ack       <= 1'b0;
            bus.d_rdata     <= '0;
            bus.mem_mreq    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
            bus.bus_err     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            busy_cnt        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            bus.if_ack  <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.if_req || pick_gnt == GNT_FETCH) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != MAX_WAIT_C) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (pick_valid) begin
                        state        <= BUSY;
                        gnt_q        <= pick_gnt;
                        bus.mem_mreq <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        busy_cnt     <= '0;
`endif
                        if (pick_gnt == GNT_DATA) begin
                            write_q         <= bus.d_write;
                            bus.mem_write   <= bus.d_write;
                            bus.mem_addr    <= bus.d_addr;
                            bus.mem_wr_data <= bus.d_write ? bus.d_wdata : '0;
                        end else begin
                            write_q         <= 1'b0;
                            bus.mem_write   <= 1'b0;
                            bus.mem_addr    <= bus.if_addr;
                            bus.mem_wr_data <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (resp_done) begin
                        state           <= RESP;
                        bus.mem_mreq    <= 1'b0;
                        bus.mem_write   <= 1'b0;
                        bus.mem_wr_data <= '0;
                        bus.bus_err     <= resp_err;
                        if (gnt_q == GNT_DATA) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= write_q ? '0 : resp_data;
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= resp_data;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] last_if_rdata = '0;
    logic [31:0] last_d_rdata  = '0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_write;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] rd_data;
        int          delay;
        logic        exp_data;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic [31:0] rd, input int dl, input logic ed,
                                input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
                                input logic [31:0] er, input int el);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;   v.d_write = dw;
        v.d_addr = da;  v.d_wdata = dd;  v.rd_data = rd; v.delay = dl;
        v.exp_data = ed; v.exp_addr = ea; v.exp_write = ew; v.exp_wdata = ewd;
        v.exp_rdata = er; v.exp_lat = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req    = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        step();
    endtask

    // Must be entered in an IDLE cycle; returns in the IDLE cycle after the ack.
    task automatic run_txn(input vec_t v, input string tag, output logic saw_data);
        int   cyc;
        int   busy;
        logic got;
        cyc  = 0;
        busy = 0;
        got  = 1'b0;
        bus.if_req      = v.if_req;
        bus.if_addr     = v.if_addr;
        bus.d_req       = v.d_req;
        bus.d_write     = v.d_write;
        bus.d_addr      = v.d_addr;
        bus.d_wdata     = v.d_wdata;
        bus.mem_ready   = 1'($urandom);
        bus.mem_rd_data = $urandom;
        while (!got && cyc < 60) begin
            step();
            cyc++;
            bus.mem_ready = 1'b0;
            if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) begin
                got = 1'b1;
            end else begin
                check_b({tag, "_mreq"}, bus.mem_mreq, 1'b1);
                check({tag, "_mem_addr"}, bus.mem_addr, v.exp_addr);
                check_b({tag, "_mem_write"}, bus.mem_write, v.exp_write);
                check({tag, "_mem_wr_data"}, bus.mem_wr_data, v.exp_wdata);
                if (busy == v.delay) begin
                    bus.mem_ready   = 1'b1;
                    bus.mem_rd_data = v.rd_data;
                end else begin
                    bus.mem_rd_data = $urandom;
                end
                busy++;
            end
        end
        saw_data = bus.d_ack;
        check_b({tag, "_ack_seen"}, got, 1'b1);
        check({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
        check_b({tag, "_d_ack"}, bus.d_ack, v.exp_data);
        check_b({tag, "_if_ack"}, bus.if_ack, !v.exp_data);
        check_b({tag, "_bus_err"}, bus.bus_err, 1'b0);
        check_b({tag, "_resp_mreq"}, bus.mem_mreq, 1'b0);
        check({tag, "_resp_wr_data"}, bus.mem_wr_data, 32'd0);
        if (v.exp_data) last_d_rdata = v.exp_rdata;
        else            last_if_rdata = v.exp_rdata;
        check({tag, "_if_rdata"}, bus.if_rdata, last_if_rdata);
        check({tag, "_d_rdata"}, bus.d_rdata, last_d_rdata);
        if (bus.d_ack === 1'b1)       bus.d_req  = 1'b0;
        else if (bus.if_ack === 1'b1) bus.if_req = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check_b({tag, "_ack_pulse"}, bus.if_ack | bus.d_ack, 1'b0);
        check({tag, "_hold_if_rdata"}, bus.if_rdata, last_if_rdata);
        check({tag, "_hold_d_rdata"}, bus.d_rdata, last_d_rdata);
    endtask

    vec_t table_v[7];

    initial begin
        logic sd;
        // ---- reset state ----
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_write = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rd_data = 0; bus.mem_ready = 0;
        step();
        step();
        check_b("rst_mreq", bus.mem_mreq, 1'b0);
        check_b("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wr_data", bus.mem_wr_data, 32'd0);
        check_b("rst_acks", bus.if_ack | bus.d_ack, 1'b0);
        check("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        check_b("rst_bus_err", bus.bus_err, 1'b0);
        #3 rst_n = 1'b1;
        step();

        // ---- directed vector table ----
        //                  ir ia          dr dw da          dd            rd            dl ed ea          ew ewd           er            lat
        table_v[0] = mk(0, 32'h0,   1, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 32'h100, 0, 32'h0,        32'hDEADBEEF, 2);
        table_v[1] = mk(0, 32'h0,   1, 1, 32'h40,  32'h12345678, 32'hAAAA5555, 0, 1, 32'h40,  1, 32'h12345678, 32'h0,        2);
        table_v[2] = mk(1, 32'h200, 0, 0, 32'h0,   32'h0,        32'h00000013, 0, 0, 32'h200, 0, 32'h0,        32'h00000013, 2);
        table_v[3] = mk(0, 32'h0,   1, 0, 32'h104, 32'h99999999, 32'hCAFEF00D, 5, 1, 32'h104, 0, 32'h0,        32'hCAFEF00D, 7);
        table_v[4] = mk(1, 32'h400, 1, 0, 32'h300, 32'h0,        32'h11223344, 1, 1, 32'h300, 0, 32'h0,        32'h11223344, 3);
        table_v[5] = mk(1, 32'h208, 0, 1, 32'h50,  32'h77,       32'h00000055, 3, 0, 32'h208, 0, 32'h0,        32'h00000055, 5);
        table_v[6] = mk(1, 32'h404, 1, 1, 32'h44,  32'hFFFF0000, 32'h0BADF00D, 2, 1, 32'h44,  1, 32'hFFFF0000, 32'h0,        4);
        for (int i = 0; i < 7; i++) begin
            run_txn(table_v[i], $sformatf("vec%0d", i), sd);
            idle();
        end

        // ---- contention: both requests held, expect DDDDF repeating ----
        for (int k = 0; k < 15; k++) begin
            logic ed;
            ed = (k % 5) != 4;
            run_txn(mk(1, 32'h800 + 32'(4 * k), 1, 0, 32'h900, 32'h0, 32'h1000 + 32'(k), 0,
                       ed, ed ? 32'h900 : 32'h800 + 32'(4 * k), 0, 32'h0, 32'h1000 + 32'(k), 2),
                    $sformatf("contend%0d", k), sd);
        end
        idle();

        // ---- reset in the middle of a BUSY access ----
        bus.d_req = 1; bus.d_write = 0; bus.d_addr = 32'h120; bus.mem_ready = 0;
        step();
        check_b("midrst_busy_mreq", bus.mem_mreq, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_b("midrst_mreq", bus.mem_mreq, 1'b0);
        check_b("midrst_acks", bus.if_ack | bus.d_ack, 1'b0);
        check_b("midrst_bus_err", bus.bus_err, 1'b0);
        check("midrst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        last_if_rdata = '0;
        last_d_rdata  = '0;
        bus.mem_ready = 1;
        step();
        step();
        bus.d_req = 0; bus.mem_ready = 0;
        #3 rst_n = 1'b1;
        step();
        check_b("midrst_no_ack", bus.if_ack | bus.d_ack, 1'b0);
        run_txn(mk(0, 32'h0, 1, 0, 32'h180, 32'h0, 32'h5A5A5A5A, 1, 1, 32'h180, 0, 32'h0,
                   32'h5A5A5A5A, 3), "post_rst", sd);
        idle();

`ifdef ARB_TIMEOUT_EN
        // ---- timeout abort: memory never ready ----
        begin
            int   n;
            logic got;
            n = 0;
            got = 0;
            bus.d_req = 1; bus.d_write = 0; bus.d_addr = 32'h1F0; bus.mem_ready = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                step();
                if (bus.d_ack === 1'b1) got = 1'b1;
                else if (bus.mem_mreq === 1'b1) n++;
            end
            check_b("to_ack_seen", got, 1'b1);
            check("to_busy_cycles", 32'(n), 32'(TIMEOUT));
            check_b("to_bus_err", bus.bus_err, 1'b1);
            check("to_rdata", bus.d_rdata, 32'd0);
            last_d_rdata = '0;
            bus.d_req = 0;
            step();
            check_b("to_err_pulse", bus.bus_err | bus.d_ack, 1'b0);
        end
`else
        // ---- long wait: without the timeout feature BUSY just waits ----
        run_txn(mk(1, 32'h3C0, 0, 0, 32'h0, 32'h0, 32'h76543210, 30, 0, 32'h3C0, 0, 32'h0,
                   32'h76543210, 32), "long_wait", sd);
`endif
        idle();

        // ---- randomized traffic against a transaction-level model ----
        begin
            logic        fp, dp, dw, ed;
            logic [31:0] fa, da, dd, rd;
            int          losses, fetch_lost, dl;
            fp = 0; dp = 0; dw = 0; fa = 0; da = 0; dd = 0;
            losses = 0;
            fetch_lost = 0;
            for (int t = 0; t < 80; t++) begin
                if (!fp && $urandom_range(0, 9) < 6) begin
                    fp = 1; fa = $urandom & 32'hFFFF_FFFC;
                end
                if (!dp && $urandom_range(0, 9) < 6) begin
                    dp = 1; da = $urandom & 32'hFFFF_FFFC; dd = $urandom; dw = 1'($urandom);
                end
                if (!fp) losses = 0;
                if (!fp && !dp) begin
                    idle();
                    continue;
                end
                ed = dp && (!fp || losses < MAX_WAIT);
                if (ed && fp) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
                else          losses = 0;
                rd = $urandom;
                dl = int'($urandom_range(0, 3));
                run_txn(mk(fp, fa, dp, dw, da, dd, rd, dl, ed,
                           ed ? da : fa, ed & dw, (ed & dw) ? dd : 32'h0,
                           (ed & dw) ? 32'h0 : rd, 2 + dl),
                        $sformatf("rnd%0d", t), sd);
                if (sd && fp) fetch_lost++;
                if (!sd) begin
                    check_b($sformatf("rnd%0d_fairness", t), fetch_lost <= MAX_WAIT, 1'b1);
                    fetch_lost = 0;
                end
                if (ed) dp = 0;
                else    fp = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
